wallace_reduce_pipe: RTL and testbench

WALLACE_REDUCE_PIPE -- requirements
Module: wallace_reduce_pipe

---
 rtl/wallace_reduce_pipe_if.sv | 23 ++
 rtl/wallace_reduce_pipe.sv | 133 +++++++++++++
 tb/tb_wallace_reduce_pipe.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/wallace_reduce_pipe_if.sv
// Handshake and data bundle for the two-stage Wallace carry-save multiplier.
// The master side feeds operand pairs and accepts result rows; the slave side
// is the reduction pipeline itself.
interface wallace_reduce_pipe_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] row_s;
  logic [31:0] row_c;

  modport master (
    output in_valid, op_a, op_b, out_ready,
    input  in_ready, out_valid, row_s, row_c
  );

  modport slave (
    input  in_valid, op_a, op_b, out_ready,
    output in_ready, out_valid, row_s, row_c
  );
endinterface

// File: rtl/wallace_reduce_pipe.sv
// 16x16 unsigned multiplier front end: partial products are reduced with 3:2
// carry-save layers over two pipeline stages and leave as a sum/carry row pair.
// A 32-bit adder downstream (Cin=0) produces the full product.
// Stage 1: 16 -> 11 -> 8 -> 6 -> 4 rows, registered with valid r_v1.
// Stage 2: 4 -> 3 -> 2 rows, registered into row_s/row_c with valid r_v2.
module wallace_reduce_pipe (
  input  logic                 clk,
  input  logic                 rst_n,
  wallace_reduce_pipe_if.slave bus
);

  // 3:2 compressor sum output, bitwise across a 32-bit row.
  function automatic logic [31:0] csa_sum(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] c);
    csa_sum = a ^ b ^ c;
  endfunction

  // 3:2 compressor carry output, moved up one bit weight; bit 31 carry is
  // dropped so all arithmetic stays modulo 2^32 and bit 0 is always zero.
  function automatic logic [31:0] csa_carry(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] c);
    logic [31:0] maj;
    maj = (a & b) | (a & c) | (b & c);
    csa_carry = {maj[30:0], 1'b0};
  endfunction

  // Stage-1 rows and valid
  logic [31:0] r_s1_row [4];
  logic        r_v1;
  // Stage-2 rows and valid (drive the outputs directly)
  logic [31:0] r_row_s;
  logic [31:0] r_row_c;
  logic        r_v2;

  // Handshake: a stage may load when it is empty or its successor loads.
  logic w_ld2;
  logic w_ld1;

  assign w_ld2 = !r_v2 || bus.out_ready;
  assign w_ld1 = !r_v1 || w_ld2;

  assign bus.in_ready  = w_ld1;
  assign bus.out_valid = r_v2;
  assign bus.row_s     = r_row_s;
  assign bus.row_c     = r_row_c;

  // Reduction tree wires
  logic [31:0] w_pp [16];
  logic [31:0] w_l1 [11];
  logic [31:0] w_l2 [8];
  logic [31:0] w_l3 [6];
  logic [31:0] w_l4 [4];
  logic [31:0] w_m  [3];
  logic [31:0] w_fin_s;
  logic [31:0] w_fin_c;

  // Stage-1 combinational tree: partial products then four 3:2 layers.
  always_comb begin
    w_pp = '{default: 32'h0000_0000};
    w_l1 = '{default: 32'h0000_0000};
    w_l2 = '{default: 32'h0000_0000};
    w_l3 = '{default: 32'h0000_0000};
    w_l4 = '{default: 32'h0000_0000};
    for (int j = 0; j < 16; j++) begin
      w_pp[j] = {16'h0000, bus.op_a & {16{bus.op_b[j]}}} << j;
    end
    // 16 -> 11: five compressors, last partial product passes through
    for (int i = 0; i < 5; i++) begin
      w_l1[2*i]   = csa_sum  (w_pp[3*i], w_pp[3*i+1], w_pp[3*i+2]);
      w_l1[2*i+1] = csa_carry(w_pp[3*i], w_pp[3*i+1], w_pp[3*i+2]);
    end
    w_l1[10] = w_pp[15];
    // 11 -> 8: three compressors, two rows pass through
    for (int i = 0; i < 3; i++) begin
      w_l2[2*i]   = csa_sum  (w_l1[3*i], w_l1[3*i+1], w_l1[3*i+2]);
      w_l2[2*i+1] = csa_carry(w_l1[3*i], w_l1[3*i+1], w_l1[3*i+2]);
    end
    w_l2[6] = w_l1[9];
    w_l2[7] = w_l1[10];
    // 8 -> 6: two compressors, two rows pass through
    for (int i = 0; i < 2; i++) begin
      w_l3[2*i]   = csa_sum  (w_l2[3*i], w_l2[3*i+1], w_l2[3*i+2]);
      w_l3[2*i+1] = csa_carry(w_l2[3*i], w_l2[3*i+1], w_l2[3*i+2]);
    end
    w_l3[4] = w_l2[6];
    w_l3[5] = w_l2[7];
    // 6 -> 4: two compressors
    for (int i = 0; i < 2; i++) begin
      w_l4[2*i]   = csa_sum  (w_l3[3*i], w_l3[3*i+1], w_l3[3*i+2]);
      w_l4[2*i+1] = csa_carry(w_l3[3*i], w_l3[3*i+1], w_l3[3*i+2]);
    end
  end

  // Stage-2 combinational tree: 4 -> 3 -> 2 rows from the stage-1 registers.
  always_comb begin
    w_m[0]  = csa_sum  (r_s1_row[0], r_s1_row[1], r_s1_row[2]);
    w_m[1]  = csa_carry(r_s1_row[0], r_s1_row[1], r_s1_row[2]);
    w_m[2]  = r_s1_row[3];
    w_fin_s = csa_sum  (w_m[0], w_m[1], w_m[2]);
    w_fin_c = csa_carry(w_m[0], w_m[1], w_m[2]);
  end

  // Stage-1 register: takes a new pair or a bubble whenever it may load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1     <= 1'b0;
      r_s1_row <= '{default: 32'h0000_0000};
    end else if (w_ld1) begin
      r_v1 <= bus.in_valid;
      if (bus.in_valid) begin
        r_s1_row <= w_l4;
      end
    end
  end

  // Stage-2 register: holds the outputs stable while downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v2    <= 1'b0;
      r_row_s <= 32'h0000_0000;
      r_row_c <= 32'h0000_0000;
    end else if (w_ld2) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_row_s <= w_fin_s;
        r_row_c <= w_fin_c;
      end
    end
  end

endmodule

// File: tb/tb_wallace_reduce_pipe.sv
// Scoreboard bench for wallace_reduce_pipe: the driver pushes the expected
// product of every accepted pair; a negedge monitor pops and compares on each
// output transfer, and also checks hold-stability while the output stalls.
module tb_wallace_reduce_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  wallace_reduce_pipe_if bus ();

  wallace_reduce_pipe dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] prod;
    int          acc_cyc;
    bit          lat;
  } item_t;

  item_t sbq[$];
  int    cyc = 0;
  int    n_pass = 0;
  int    n_chk = 0;
  bit    lat_mode = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %h required %h", name, act, exp);
  endfunction

  // Monitor: compare on every output transfer; verify rows hold during stall.
  initial begin : monitor
    logic        prev_stall;
    logic [31:0] prev_s, prev_c;
    item_t       it;
    prev_stall = 1'b0;
    prev_s = 32'h0;
    prev_c = 32'h0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("hold_valid", {31'h0, bus.out_valid}, 32'h1);
          check("hold_row_s", bus.row_s, prev_s);
          check("hold_row_c", bus.row_c, prev_c);
        end
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
          if (sbq.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_out: actual output present, required none (row_s %h row_c %h)",
                     bus.row_s, bus.row_c);
          end else begin
            it = sbq.pop_front();
            check("sum", bus.row_s + bus.row_c, it.prod);
            check("row_c0", {31'h0, bus.row_c[0]}, 32'h0);
            if (it.lat) check("latency", 32'(cyc - it.acc_cyc), 32'd2);
          end
        end
        prev_stall = (bus.out_valid === 1'b1) && (bus.out_ready === 1'b0);
        prev_s = bus.row_s;
        prev_c = bus.row_c;
      end
    end
  end

  // One cycle of stimulus; reports whether the pair was accepted.
  task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b,
                       input logic ordy, input logic [31:0] exp, output logic acc);
    item_t it;
    bus.in_valid  = v;
    bus.op_a      = a;
    bus.op_b      = b;
    bus.out_ready = ordy;
    @(negedge clk);
    acc = v && (bus.in_ready === 1'b1);
    if (acc) begin
      it.prod = exp;
      it.acc_cyc = cyc;
      it.lat = lat_mode;
      sbq.push_back(it);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    logic acc;
    int   k;
    k = 0;
    while (sbq.size() != 0 && k < 40) begin
      drive(1'b0, 16'h0000, 16'h0000, 1'b1, 32'h0, acc);
      k++;
    end
    drive(1'b0, 16'h0000, 16'h0000, 1'b1, 32'h0, acc);
    check({tag, "_drain_empty"}, 32'(sbq.size()), 32'h0);
  endtask

  // Assert reset between clock edges, check cleared state, release.
  task automatic do_reset(input string tag);
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check({tag, "_rst_out_valid"}, {31'h0, bus.out_valid}, 32'h0);
    check({tag, "_rst_row_s"}, bus.row_s, 32'h0);
    check({tag, "_rst_row_c"}, bus.row_c, 32'h0);
    check({tag, "_rst_in_ready"}, {31'h0, bus.in_ready}, 32'h1);
    sbq.delete();
    @(posedge clk);
    #1;
    check({tag, "_rst_hold_valid"}, {31'h0, bus.out_valid}, 32'h0);
    #2 rst_n = 1'b1;
    #1;
    check({tag, "_post_rst_in_ready"}, {31'h0, bus.in_ready}, 32'h1);
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: actual timeout, required finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic        acc;
    logic [15:0] a, b;
    logic        v, o;
    int          n_acc;
    logic [15:0] bp_a [5];
    logic [15:0] bp_b [5];
    logic [31:0] bp_e [5];

    bp_a = '{16'h1111, 16'h0100, 16'hAAAA, 16'h5555, 16'h0001};
    bp_b = '{16'h000F, 16'h0100, 16'h0002, 16'h0003, 16'h0001};
    bp_e = '{32'h0000FFFF, 32'h00010000, 32'h00015554, 32'h0000FFFF, 32'h00000001};

    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.op_a = 16'h0000;
    bus.op_b = 16'h0000;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    do_reset("init");

    // Directed single operations with hand-computed products
    lat_mode = 1'b1;
    drive(1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 32'hFFFE0001, acc);
    check("dir_accept", {31'h0, acc}, 32'h1);
    drive(1'b0, 16'h0000, 16'h0000, 1'b1, 32'h0, acc);
    drive(1'b0, 16'h0000, 16'h0000, 1'b1, 32'h0, acc);
    drive(1'b1, 16'h0000, 16'h1234, 1'b1, 32'h00000000, acc);
    drive(1'b1, 16'h0003, 16'h0005, 1'b1, 32'h0000000F, acc);
    drive(1'b1, 16'h8000, 16'h0002, 1'b1, 32'h00010000, acc);
    drive(1'b1, 16'hFFFF, 16'h0001, 1'b1, 32'h0000FFFF, acc);
    drive(1'b1, 16'h00FF, 16'h0101, 1'b1, 32'h0000FFFF, acc);
    drain("dir");

    // Back-to-back streaming with downstream always ready
    for (int i = 0; i < 1000; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      drive(1'b1, a, b, 1'b1, 32'(a) * 32'(b), acc);
      check("stream_in_ready", {31'h0, acc}, 32'h1);
    end
    drain("stream");

    // Backpressure from empty: only two pairs fit
    lat_mode = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, bp_a[i], bp_b[i], 1'b0, bp_e[i], acc);
      if (acc) n_acc++;
    end
    check("bp_accepted", 32'(n_acc), 32'd2);
    check("bp_last_accept", {31'h0, acc}, 32'h0);
    check("bp_in_ready_low", {31'h0, bus.in_ready}, 32'h0);
    drain("bp");

    // Bubble collapse: stage 2 stalled full, stage 1 empty -> one more fits
    drive(1'b1, 16'h0007, 16'h0009, 1'b0, 32'd63, acc);
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 32'h0, acc);
    drive(1'b1, 16'h000B, 16'h000D, 1'b0, 32'd143, acc);
    check("bubble_accept", {31'h0, acc}, 32'h1);
    drive(1'b1, 16'h0002, 16'h0002, 1'b0, 32'd4, acc);
    check("bubble_full", {31'h0, acc}, 32'h0);
    drain("bubble");

    // Random in_valid / out_ready toggling
    for (int i = 0; i < 10000; i++) begin
      v = 1'($urandom_range(1, 0));
      o = 1'($urandom_range(1, 0));
      a = 16'($urandom);
      b = 16'($urandom);
      drive(v, a, b, o, 32'(a) * 32'(b), acc);
    end
    drain("rand");

    // Mid-stream reset with both stages occupied
    drive(1'b1, 16'h1234, 16'h5678, 1'b0, 32'h06260060, acc);
    drive(1'b1, 16'h4321, 16'h0010, 1'b0, 32'h00043210, acc);
    check("pre_reset_valid", {31'h0, bus.out_valid}, 32'h1);
    do_reset("mid");
    lat_mode = 1'b1;
    drive(1'b1, 16'h00FF, 16'h00FF, 1'b1, 32'h0000FE01, acc);
    check("post_reset_accept", {31'h0, acc}, 32'h1);
    drain("post_reset");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
